// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] NOP_INSN = 32'h0;

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/insn_hold_reg.sv
// 32-bit enable register that clears to NOP_INSN; parks an instruction across a stall.
module insn_hold_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q <= NOP_INSN;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// PC generation and F/D latch driver for a synchronous instruction ROM with one-cycle latency.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     IMEM_AW  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [PC_W-1:0]    fd_pc,
    output logic [31:0]        fd_insn,
    output logic               fd_we,
    output logic               fd_flush
);

    fetch_state_e    r_state, w_state_d;
    logic [PC_W-1:0] r_pc_req, w_pc_req_d;
    logic [PC_W-1:0] r_pc_resp, w_pc_resp_d;
    logic [31:0]     w_hold_insn;
    logic            w_hold_en;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= StFill;
            r_pc_req  <= RESET_PC;
            r_pc_resp <= RESET_PC;
        end else begin
            r_state   <= w_state_d;
            r_pc_req  <= w_pc_req_d;
            r_pc_resp <= w_pc_resp_d;
        end
    end

    insn_hold_reg u_hold (
        .clk   (clk),
        .clr_n (clr_n),
        .i_en  (w_hold_en),
        .i_d   (imem_rdata),
        .o_q   (w_hold_insn)
    );

    // Redirect bypasses pc_req so the target is fetched in the flush cycle itself.
    assign imem_addr = redirect ? redirect_pc[IMEM_AW-1:0] : r_pc_req[IMEM_AW-1:0];
    assign fd_pc     = r_pc_resp;

    always_comb begin
        unique case (r_state)
            StRun:   fd_insn = imem_rdata;
            StHold:  fd_insn = w_hold_insn;
            default: fd_insn = NOP_INSN;
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_pc_req_d  = r_pc_req;
        w_pc_resp_d = r_pc_resp;
        w_hold_en   = 1'b0;
        fd_we       = 1'b0;
        fd_flush    = 1'b0;

        if (redirect) begin
            fd_flush    = 1'b1;
            w_pc_resp_d = redirect_pc;
            w_pc_req_d  = redirect_pc + PC_W'(1);
            w_state_d   = StRun;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (!stall) begin
                        w_pc_resp_d = r_pc_req;
                        w_pc_req_d  = r_pc_req + PC_W'(1);
                        w_state_d   = StRun;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        fd_we       = 1'b1;
                        w_pc_resp_d = r_pc_req;
                        w_pc_req_d  = r_pc_req + PC_W'(1);
                    end else begin
                        w_hold_en = 1'b1;
                        w_state_d = StHold;
                    end
                end
                StHold: begin
                    // ROM output is stale here; pc_req is on imem_addr again, so RUN sees its data.
                    if (!stall) begin
                        fd_we       = 1'b1;
                        w_pc_resp_d = r_pc_req;
                        w_pc_req_d  = r_pc_req + PC_W'(1);
                        w_state_d   = StRun;
                    end
                end
                default: begin
                    w_state_d = StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit against an instruction-stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] fd_pc;
    logic [31:0] fd_insn;
    logic        fd_we;
    logic        fd_flush;

    always #5 clk = ~clk;

    fetch_unit #(
        .IMEM_AW  (12),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .fd_pc       (fd_pc),
        .fd_insn     (fd_insn),
        .fd_we       (fd_we),
        .fd_flush    (fd_flush)
    );

    function automatic logic [31:0] rom_fn(input logic [11:0] a);
        return {20'h0, a} + 32'd100;
    endfunction

    always @(posedge clk) imem_rdata <= rom_fn(imem_addr);

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] insn;
    } item_t;

    item_t       q[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    // Reference: m_pc is the next instruction to hand over; m_primed is false until the
    // first fetch after reset has been issued.
    logic [31:0] m_pc     = RESET_PC;
    bit          m_primed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] rpc);
        logic [31:0] ea;
        item_t       it;
        @(posedge clk);
        #2;
        clr_n       = 1'b1;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        cyc++;
        #1;
        ea = r ? rpc : (m_primed ? m_pc + 32'd1 : m_pc);
        chk("fd_flush", {31'h0, fd_flush}, {31'h0, r});
        chk("imem_addr", {20'h0, imem_addr}, {20'h0, ea[11:0]});
        chk("fd_pc_track", fd_pc, m_pc);
        if (r) begin
            m_pc     = rpc;
            m_primed = 1'b1;
        end else if (!s) begin
            if (m_primed) begin
                it.cyc  = cyc;
                it.pc   = m_pc;
                it.insn = rom_fn(m_pc[11:0]);
                q.push_back(it);
                m_pc = m_pc + 32'd1;
            end else begin
                m_primed = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #2;
        clr_n    = 1'b0;
        stall    = 1'($urandom_range(0, 1));
        redirect = 1'b0;
        cyc++;
        #1;
        chk("rst_fd_we", {31'h0, fd_we}, 32'h0);
        chk("rst_fd_flush", {31'h0, fd_flush}, 32'h0);
        chk("rst_fd_pc", fd_pc, RESET_PC);
        chk("rst_fd_insn", fd_insn, NOP);
        chk("rst_imem_addr", {20'h0, imem_addr}, {20'h0, RESET_PC[11:0]});
        m_pc     = RESET_PC;
        m_primed = 1'b0;
        for (int i = 1; i < ncyc; i++) begin
            @(posedge clk);
            #2;
            cyc++;
        end
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                it = q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missed_we: pc %h expected at cyc %0d, got no fd_we", it.pc, it.cyc);
            end
            if (fd_we) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_we @cyc %0d: got fd_we=1 fd_pc=%h, expected no write",
                             cyc, fd_pc);
                end else begin
                    it = q.pop_front();
                    chk("fd_pc", fd_pc, it.pc);
                    chk("fd_insn", fd_insn, it.insn);
                end
            end
        end
    end

    initial begin : stim
        bit          s, r;
        logic [31:0] rpc;
        clr_n       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        do_reset(3);

        step(0, 0, 0);                                  // FILL after reset
        repeat (5) step(0, 0, 0);                       // pc 0..4
        repeat (3) step(1, 0, 0);                       // stall with pc 5 pending
        repeat (3) step(0, 0, 0);                       // pc 5,6,7
        step(0, 1, 32'h40);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);                                  // into HOLD
        step(1, 1, 32'h80);                             // redirect wins over stall
        repeat (2) step(0, 0, 0);
        step(0, 1, 32'hFFFF_FFFF);                      // wrap
        repeat (3) step(0, 0, 0);
        repeat (2) step(1, 0, 0);
        do_reset(2);                                    // mid-HOLD reset
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end
            s   = ($urandom_range(0, 99) < 30);
            r   = ($urandom_range(0, 99) < 6);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            step(s, r, rpc);
        end

        repeat (3) step(1, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
